// File: rtl/regfile_bypass_sb_if.sv
// Register-file bundle: decode read ports, writeback port and issue strobe.
// Master is the pipeline side, slave is the register file.
interface regfile_bypass_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            we_en;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] wd;
    logic            issue_en;
    logic [AW-1:0]   issue_rd;

    modport master (
        output rs1_addr, rs2_addr, we_en, rd_addr, wd,
        output issue_en, issue_rd,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy
    );

    modport slave (
        input  rs1_addr, rs2_addr, we_en, rd_addr, wd,
        input  issue_en, issue_rd,
        output rs1_data, rs2_data, rs1_busy, rs2_busy
    );
endinterface

// File: rtl/regfile_bypass_sb.sv
// Integer register file: 2 comb read ports, 1 write port,
// optional write-to-read bypass and a pending-write scoreboard.
module regfile_bypass_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter bit BYPASS = 1'b1
) (
    input logic                clk,
    input logic                resetn,
    regfile_bypass_sb_if.slave rf
);
    localparam logic [AW:0] LIMIT = (AW+1)'(NREG);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_sb;

    logic            w_wr;
    logic            w_set;
    logic [NREG-1:0] w_set_vec;
    logic [NREG-1:0] w_clr_vec;
    logic [AW-1:0]   w_ra [2];
    logic [XLEN-1:0] w_rd [2];
    logic            w_rb [2];

    function automatic logic in_rng(logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < LIMIT);
    endfunction

    // Gated by resetn so nothing is forwarded while reset is held.
    assign w_wr  = resetn && rf.we_en && in_rng(rf.rd_addr);
    assign w_set = rf.issue_en && in_rng(rf.issue_rd);

    always_comb begin
        w_set_vec = '0;
        w_clr_vec = '0;
        if (w_set) w_set_vec[rf.issue_rd] = 1'b1;
        if (w_wr)  w_clr_vec[rf.rd_addr]  = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_sb <= '0;
        end else begin
            if (w_wr) r_regs[rf.rd_addr] <= rf.wd;
            // Set applied after clear: a newer producer wins.
            r_sb <= ((r_sb & ~w_clr_vec) | w_set_vec) & ~NREG'(1);
        end
    end

    assign w_ra[0] = rf.rs1_addr;
    assign w_ra[1] = rf.rs2_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd[p] = '0;
            w_rb[p] = 1'b0;
            if (in_rng(w_ra[p])) begin
                w_rd[p] = r_regs[w_ra[p]];
                w_rb[p] = r_sb[w_ra[p]];
                if (BYPASS && w_wr && rf.rd_addr == w_ra[p]) begin
                    w_rd[p] = rf.wd;
                    if (!(rf.issue_en && rf.issue_rd == w_ra[p]))
                        w_rb[p] = 1'b0;
                end
            end
        end
    end

    assign rf.rs1_data = w_rd[0];
    assign rf.rs2_data = w_rd[1];
    assign rf.rs1_busy = w_rb[0];
    assign rf.rs2_busy = w_rb[1];
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: vector table with expected-value queue,
// plus reset, BYPASS=0 and 64-bit/16-register sequences.
module tb_regfile_bypass_sb;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    regfile_bypass_sb_if #(.XLEN(32), .AW(5)) rf1 ();
    regfile_bypass_sb_if #(.XLEN(32), .AW(5)) rf0 ();
    regfile_bypass_sb_if #(.XLEN(64), .AW(4)) rf64 ();

    regfile_bypass_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) dut (
        .clk(clk), .resetn(resetn), .rf(rf1)
    );
    regfile_bypass_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) dut0 (
        .clk(clk), .resetn(resetn), .rf(rf0)
    );
    regfile_bypass_sb #(.XLEN(64), .NREG(16), .BYPASS(1'b1)) dut64 (
        .clk(clk), .resetn(resetn), .rf(rf64)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        iss;
        logic [4:0]  ird;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
    } vec_t;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
    } exp_t;

    vec_t vecs[$];
    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic add(input logic we, input logic [4:0] rd,
                       input logic [31:0] wd, input logic iss,
                       input logic [4:0] ird, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [31:0] d1,
                       input logic [31:0] d2, input logic b1,
                       input logic b2);
        vec_t v;
        v = '{we, rd, wd, iss, ird, a1, a2, d1, d2, b1, b2};
        vecs.push_back(v);
    endtask

    task automatic idle_all();
        rf1.we_en = 0; rf1.rd_addr = 0; rf1.wd = 0;
        rf1.issue_en = 0; rf1.issue_rd = 0;
        rf0.we_en = 0; rf0.rd_addr = 0; rf0.wd = 0;
        rf0.issue_en = 0; rf0.issue_rd = 0;
        rf64.we_en = 0; rf64.rd_addr = 0; rf64.wd = 0;
        rf64.issue_en = 0; rf64.issue_rd = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        idle_all();
        rf1.rs1_addr = 5; rf1.rs2_addr = 9;
        rf0.rs1_addr = 0; rf0.rs2_addr = 0;
        rf64.rs1_addr = 0; rf64.rs2_addr = 0;
        #1;
        chk("reset_rs1_data", rf1.rs1_data, 0);
        chk("reset_rs2_busy", rf1.rs2_busy, 0);
        @(negedge clk);
        resetn = 1'b1;

        add(0,  0, 32'h0,        0, 0,  0,  5, 32'h0,        32'h0,        0, 0);
        add(1,  0, 32'hDEADBEEF, 0, 0,  0,  0, 32'h0,        32'h0,        0, 0);
        add(1,  5, 32'h12345678, 0, 0,  5,  3, 32'h12345678, 32'h0,        0, 0);
        add(0,  0, 32'h0,        0, 0,  5,  5, 32'h12345678, 32'h12345678, 0, 0);
        add(1,  7, 32'hA5A5A5A5, 0, 0,  5,  7, 32'h12345678, 32'hA5A5A5A5, 0, 0);
        add(0,  0, 32'h0,        1, 9,  9,  7, 32'h0,        32'hA5A5A5A5, 0, 0);
        add(0,  0, 32'h0,        0, 0,  9,  0, 32'h0,        32'h0,        1, 0);
        add(1,  9, 32'h11111111, 1, 9,  9,  9, 32'h11111111, 32'h11111111, 1, 1);
        add(0,  0, 32'h0,        0, 0,  9,  9, 32'h11111111, 32'h11111111, 1, 1);
        add(1,  9, 32'h22222222, 0, 0,  9,  5, 32'h22222222, 32'h12345678, 0, 0);
        add(0,  0, 32'h0,        0, 0,  9,  9, 32'h22222222, 32'h22222222, 0, 0);
        add(1,  5, 32'h00000055, 1, 3,  3,  5, 32'h0,        32'h00000055, 0, 0);
        add(0,  0, 32'h0,        0, 0,  3,  5, 32'h0,        32'h00000055, 1, 0);
        add(0,  0, 32'h0,        1, 0,  0,  3, 32'h0,        32'h0,        0, 1);
        add(0,  0, 32'h0,        0, 0,  0,  3, 32'h0,        32'h0,        0, 1);
        add(1, 31, 32'hFFFFFFFF, 1, 3, 31,  3, 32'hFFFFFFFF, 32'h0,        0, 1);
        add(0,  0, 32'h0,        0, 0, 31, 30, 32'hFFFFFFFF, 32'h0,        0, 0);
        add(1,  3, 32'h00000033, 0, 0,  3,  3, 32'h00000033, 32'h00000033, 0, 0);
        add(0,  0, 32'h0,        0, 0,  3,  2, 32'h00000033, 32'h0,        0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rf1.we_en = vecs[i].we;
            rf1.rd_addr = vecs[i].rd;
            rf1.wd = vecs[i].wd;
            rf1.issue_en = vecs[i].iss;
            rf1.issue_rd = vecs[i].ird;
            rf1.rs1_addr = vecs[i].a1;
            rf1.rs2_addr = vecs[i].a2;
            q.push_back('{vecs[i].d1, vecs[i].d2, vecs[i].b1, vecs[i].b2});
            #1;
            e = q.pop_front();
            chk($sformatf("v%0d_rs1_data", i), rf1.rs1_data, e.d1);
            chk($sformatf("v%0d_rs2_data", i), rf1.rs2_data, e.d2);
            chk($sformatf("v%0d_rs1_busy", i), rf1.rs1_busy, e.b1);
            chk($sformatf("v%0d_rs2_busy", i), rf1.rs2_busy, e.b2);
        end

        // Mid-operation asynchronous reset.
        @(negedge clk);
        idle_all();
        rf1.issue_en = 1; rf1.issue_rd = 10;
        rf1.rs1_addr = 5; rf1.rs2_addr = 31;
        #1;
        chk("pre_rst_x5", rf1.rs1_data, 32'h55);
        chk("pre_rst_x31", rf1.rs2_data, 32'hFFFFFFFF);
        @(negedge clk);
        idle_all();
        rf1.rs2_addr = 10;
        #1;
        chk("pre_rst_x10_busy", rf1.rs2_busy, 1);
        resetn = 1'b0;
        rf1.we_en = 1; rf1.rd_addr = 5; rf1.wd = 32'h99;
        rf1.issue_en = 1; rf1.issue_rd = 12;
        #1;
        chk("in_rst_x5", rf1.rs1_data, 0);
        chk("in_rst_x10_busy", rf1.rs2_busy, 0);
        @(posedge clk);
        #1;
        chk("in_rst_edge_x5", rf1.rs1_data, 0);
        @(negedge clk);
        resetn = 1'b1;
        idle_all();
        rf1.rs1_addr = 12; rf1.rs2_addr = 31;
        #1;
        chk("post_rst_x12_busy", rf1.rs1_busy, 0);
        chk("post_rst_x31", rf1.rs2_data, 0);
        @(negedge clk);
        rf1.rs1_addr = 5;
        #1;
        chk("post_rst_x5", rf1.rs1_data, 0);

        // BYPASS=0 instance.
        @(negedge clk);
        rf0.we_en = 1; rf0.rd_addr = 7; rf0.wd = 32'hA5A5A5A5;
        rf0.rs2_addr = 7;
        #1;
        chk("nb_same_cycle_x7", rf0.rs2_data, 0);
        @(negedge clk);
        idle_all();
        #1;
        chk("nb_after_edge_x7", rf0.rs2_data, 32'hA5A5A5A5);
        rf0.issue_en = 1; rf0.issue_rd = 9;
        @(negedge clk);
        idle_all();
        rf0.rs1_addr = 9;
        #1;
        chk("nb_x9_busy", rf0.rs1_busy, 1);
        rf0.we_en = 1; rf0.rd_addr = 9; rf0.wd = 32'h1;
        #1;
        chk("nb_wb_busy", rf0.rs1_busy, 1);
        chk("nb_wb_old_data", rf0.rs1_data, 0);
        @(negedge clk);
        idle_all();
        #1;
        chk("nb_x9_cleared", rf0.rs1_busy, 0);
        chk("nb_x9_data", rf0.rs1_data, 32'h1);

        // 64-bit, 16-register instance.
        @(negedge clk);
        rf64.we_en = 1; rf64.rd_addr = 15;
        rf64.wd = 64'hFFFF0000FFFF0000;
        @(negedge clk);
        rf64.rd_addr = 1; rf64.wd = 64'h0123456789ABCDEF;
        rf64.rs1_addr = 15;
        #1;
        chk("w64_x15", rf64.rs1_data, 64'hFFFF0000FFFF0000);
        @(negedge clk);
        rf64.rd_addr = 0; rf64.wd = '1;
        rf64.rs1_addr = 1; rf64.rs2_addr = 0;
        #1;
        chk("w64_x1", rf64.rs1_data, 64'h0123456789ABCDEF);
        chk("w64_x0_bypass", rf64.rs2_data, 0);
        @(negedge clk);
        idle_all();
        rf64.rs1_addr = 15; rf64.rs2_addr = 0;
        #1;
        chk("w64_x15_hold", rf64.rs1_data, 64'hFFFF0000FFFF0000);
        chk("w64_x0_zero", rf64.rs2_data, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
